// File: rtl/branch_gshare_spec.sv
// Gshare direction predictor with split predict/resolve ports.
// After reset, the table-initialisation FSM walks every PHT entry and writes
// the weakly-not-taken value. Traffic is accepted only once ready_o is high.
// The speculative history is shifted on each prediction. A mispredict
// restores it from the checkpoint returned at predict time.
//
// state | meaning
// INIT  | writing weakly-not-taken into PHT[init_ptr]; ports ignored
// RUN   | table valid; predict, train, history repair, mispredict count
module branch_gshare_spec #(
    parameter int PHT_SIZE  = 2048,
    parameter int HIST_BITS = 11,
    parameter int CTR_BITS  = 2,
    localparam int AW       = $clog2(PHT_SIZE)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    output logic                 ready_o,
    input  logic                 pred_en_i,
    input  logic [31:0]          pred_pc_i,
    output logic                 pred_taken_o,
    output logic [AW-1:0]        pred_idx_o,
    output logic [HIST_BITS-1:0] pred_hist_o,
    input  logic                 upd_en_i,
    input  logic [AW-1:0]        upd_idx_i,
    input  logic [HIST_BITS-1:0] upd_hist_i,
    input  logic                 upd_taken_i,
    input  logic                 upd_mispred_i,
    output logic [31:0]          mispred_count_o
);

    localparam logic [0:0]          ST_INIT  = 1'b0;
    localparam logic [0:0]          ST_RUN   = 1'b1;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [AW-1:0]       PTR_LAST = AW'(PHT_SIZE - 1);

    logic [0:0]           state_q, state_d;
    logic [AW-1:0]        init_ptr_q, init_ptr_d;
    logic [HIST_BITS-1:0] spec_hist_q, spec_hist_d;
    logic [31:0]          mispred_count_q, mispred_count_d;
    logic [CTR_BITS-1:0]  pht_q [PHT_SIZE];

    logic                 ready;
    logic                 repair;
    logic [AW-1:0]        hist_ext;
    logic [CTR_BITS-1:0]  upd_ctr;
    logic [CTR_BITS-1:0]  upd_ctr_next;
    logic                 unused_pc_bits;

    // Shift a new outcome into a history word; truncation keeps HIST_BITS=1 legal.
    function automatic logic [HIST_BITS-1:0] hist_push(input logic [HIST_BITS-1:0] h,
                                                       input logic b);
        return HIST_BITS'({h, b});
    endfunction

    assign ready          = (state_q == ST_RUN);
    assign repair         = ready && upd_en_i && upd_mispred_i;
    assign unused_pc_bits = ^{pred_pc_i[31:AW+2], pred_pc_i[1:0]};

    // Zero-extend the history to the index width and hash it with the PC.
    always_comb begin
        hist_ext                  = '0;
        hist_ext[HIST_BITS-1:0]   = spec_hist_q;
        pred_idx_o                = pred_pc_i[AW+1:2] ^ hist_ext;
    end

    assign pred_taken_o    = ready && pht_q[pred_idx_o][CTR_BITS-1];
    assign pred_hist_o     = spec_hist_q;
    assign ready_o         = ready;
    assign mispred_count_o = mispred_count_q;

    // Saturating next value for the counter being trained.
    always_comb begin
        upd_ctr      = pht_q[upd_idx_i];
        upd_ctr_next = upd_ctr;
        if (upd_taken_i) begin
            if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + 1'b1;
        end else begin
            if (upd_ctr != '0) upd_ctr_next = upd_ctr - 1'b1;
        end
    end

    // Next-state for the FSM, init pointer, speculative history and counter.
    always_comb begin
        state_d         = state_q;
        init_ptr_d      = init_ptr_q;
        spec_hist_d     = spec_hist_q;
        mispred_count_d = mispred_count_q;
        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == PTR_LAST) state_d = ST_RUN;
        end else begin
            // A repair wins over a same-cycle predict shift.
            if (repair) begin
                spec_hist_d = hist_push(upd_hist_i, upd_taken_i);
                if (mispred_count_q != 32'hFFFF_FFFF)
                    mispred_count_d = mispred_count_q + 32'd1;
            end else if (pred_en_i) begin
                spec_hist_d = hist_push(spec_hist_q, pred_taken_o);
            end
        end
    end

    // Control registers; reset returns to INIT and clears history and count.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= ST_INIT;
            init_ptr_q      <= '0;
            spec_hist_q     <= '0;
            mispred_count_q <= '0;
        end else begin
            state_q         <= state_d;
            init_ptr_q      <= init_ptr_d;
            spec_hist_q     <= spec_hist_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    // PHT storage: the INIT sweep fills it, so it needs no reset of its own.
    // Reads above use the pre-edge contents, so a same-index predict sees the old value.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            pht_q[init_ptr_q] <= CTR_INIT;
        end else if (upd_en_i) begin
            pht_q[upd_idx_i] <= upd_ctr_next;
        end
    end

endmodule
